// File: rtl/ac2_serial_acc_pkg.sv
// Shared widths, FSM state type and weight-precision legalisation for the
// AC2 bit-serial accumulator.
package smac_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  function automatic int in_width(input int m, input int pa);
    return $clog2(m) + pa + 1;
  endfunction

  function automatic int acc_width(input int m, input int pa, input int pw_max);
    return in_width(m, pa) + pw_max;
  endfunction

  function automatic int cnt_width(input int pw_max);
    return $clog2(pw_max + 1);
  endfunction

  // A precision of zero or beyond the datapath maximum runs at full precision.
  function automatic int unsigned legal_wbits(input int unsigned wbits, input int unsigned pw_max);
    if ((wbits == 32'd0) || (wbits > pw_max)) begin
      return pw_max;
    end else begin
      return wbits;
    end
  endfunction

endpackage

// File: rtl/ac2_serial_acc_if.sv
// Beat input, result output and status bundle between the serial MAC
// datapath (master) and the AC2 accumulator (slave).
interface ac2_serial_acc_if import smac_pkg::*; #(
  parameter int M      = 16,
  parameter int PA     = 8,
  parameter int PW_MAX = 8,
  parameter int LANES  = 4
) ();
  localparam int IN_W = in_width(M, PA);
  localparam int AW   = acc_width(M, PA, PW_MAX);
  localparam int CW   = cnt_width(PW_MAX);

  logic [CW-1:0]         wbits;
  logic                  w_signed;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] pp;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*AW-1:0]   acc;
  logic                  busy;

  modport master (
    output wbits, w_signed, in_valid, pp, out_ready,
    input  in_ready, out_valid, acc, busy
  );

  modport slave (
    input  wbits, w_signed, in_valid, pp, out_ready,
    output in_ready, out_valid, acc, busy
  );
endinterface

// File: rtl/ac2_serial_acc_lane.sv
// ac2_lane: one Horner accumulator lane, R = 2R + sext(pp) with the MSB beat
// optionally negated when SMAC_SIGNED_W_EN is defined.
module ac2_lane #(
  parameter int IN_W = 13,
  parameter int AW   = 21
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            first_i,
  input  logic            neg_i,
  input  logic [IN_W-1:0] pp_i,
  output logic [AW-1:0]   sum_o
);
  logic [AW-1:0] r_q, r_d;
  logic [AW-1:0] pp_ext_s, term_s, base_s;

  assign pp_ext_s = {{(AW-IN_W){pp_i[IN_W-1]}}, pp_i};

`ifdef SMAC_SIGNED_W_EN
  assign term_s = neg_i ? (-pp_ext_s) : pp_ext_s;
`else
  logic unused_neg_s;
  assign unused_neg_s = neg_i;
  assign term_s       = pp_ext_s;
`endif

  // The first beat starts from zero so a stale R never leaks into a new op.
  assign base_s = first_i ? {AW{1'b0}} : {r_q[AW-2:0], 1'b0};
  assign sum_o  = base_s + term_s;

  // Next value of the running sum.
  always_comb begin
    r_d = r_q;
    if (clr_i) begin
      r_d = {AW{1'b0}};
    end else if (en_i) begin
      r_d = sum_o;
    end else begin
      r_d = r_q;
    end
  end

  // Running-sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= {AW{1'b0}};
    end else begin
      r_q <= r_d;
    end
  end
endmodule

// File: rtl/ac2_serial_acc.sv
// AC2 multi-lane bit-serial weight accumulator: shared FSM, bit counter and
// result handshake. Signed weights are built only with SMAC_SIGNED_W_EN.
module ac2_serial_acc import smac_pkg::*; #(
  parameter int M      = 16,
  parameter int PA     = 8,
  parameter int PW_MAX = 8,
  parameter int LANES  = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             cl_en_i,
  ac2_serial_acc_if.slave bus
);
  localparam int IN_W = in_width(M, PA);
  localparam int AW   = acc_width(M, PA, PW_MAX);
  localparam int CW   = cnt_width(PW_MAX);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, wb_q, wb_d;
  logic [LANES*AW-1:0] acc_out_q, acc_out_d, sum_s;
  logic                out_valid_q, out_valid_d;
  logic                first_s, final_s, beat_s, in_ready_s, neg_s;
  logic [CW-1:0]       wb_new_s, wb_eff_s, cnt_inc_s;

  assign first_s   = (state_q == IDLE);
  assign wb_new_s  = CW'(legal_wbits(32'(bus.wbits), 32'(PW_MAX)));
  assign wb_eff_s  = first_s ? wb_new_s : wb_q;
  assign cnt_inc_s = cnt_q + {{(CW-1){1'b0}}, 1'b1};
  assign final_s   = (cnt_inc_s == wb_eff_s);
  // Only a final beat can collide with an unconsumed result.
  assign in_ready_s = !(final_s && out_valid_q && !bus.out_ready);
  assign beat_s     = bus.in_valid && in_ready_s && !cl_en_i;

`ifdef SMAC_SIGNED_W_EN
  assign neg_s = first_s && bus.w_signed;
`else
  logic unused_w_signed_s;
  assign unused_w_signed_s = bus.w_signed;
  assign neg_s             = 1'b0;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ac2_lane #(.IN_W(IN_W), .AW(AW)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (cl_en_i),
      .en_i    (beat_s),
      .first_i (first_s),
      .neg_i   (neg_s),
      .pp_i    (bus.pp[l*IN_W +: IN_W]),
      .sum_o   (sum_s[l*AW +: AW])
    );
  end

  // FSM, counter and result next-state; cl_en leaves the result untouched.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_d        = wb_q;
    acc_out_d   = acc_out_q;
    out_valid_d = out_valid_q;
    if (cl_en_i) begin
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
    end else if (beat_s) begin
      if (first_s) begin
        wb_d = wb_new_s;
      end else begin
        wb_d = wb_q;
      end
      if (final_s) begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end else begin
        state_d = ACC;
        cnt_d   = cnt_inc_s;
      end
    end else begin
      state_d = state_q;
    end
    if (beat_s && final_s) begin
      acc_out_d   = sum_s;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      wb_q        <= CW'(PW_MAX);
      acc_out_q   <= {(LANES*AW){1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_q        <= wb_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_out_q;
  assign bus.busy      = (state_q == ACC);
endmodule

// File: tb/tb_ac2_serial_acc.sv
// Scoreboard bench for ac2_serial_acc: expected results are queued when an
// operation is driven and compared when the result is presented.
`timescale 1ns/1ps
module tb_ac2_serial_acc;
  import smac_pkg::*;
  localparam int M = 16, PA = 8, PW_MAX = 8, LANES = 4;
  localparam int IN_W = in_width(M, PA);
  localparam int AW   = acc_width(M, PA, PW_MAX);
  localparam int CW   = cnt_width(PW_MAX);
  typedef logic [LANES*AW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cl_en;
  always #5 clk = ~clk;

  ac2_serial_acc_if #(.M(M), .PA(PA), .PW_MAX(PW_MAX), .LANES(LANES)) bus ();
  ac2_serial_acc #(.M(M), .PA(PA), .PW_MAX(PW_MAX), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .cl_en_i(cl_en), .bus(bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t exp_q[$];
  int   beats [8][LANES];
  logic [7:0] busy_mask;

  function automatic vec_t model_op(input int b [8][LANES], input int n, input bit neg);
    vec_t v;
    int   r;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      r = 0;
      for (int k = 0; k < n; k++) r = r * 2 + (((k == 0) && neg) ? -b[k][l] : b[k][l]);
      v[l*AW +: AW] = AW'(r);
    end
    return v;
  endfunction

  // Drives n beats (waiting on in_ready) and queues the expected result.
  task automatic send_op(input int n, input logic [CW-1:0] wb, input bit ws);
    bit neg;
    int tries;
`ifdef SMAC_SIGNED_W_EN
    neg = ws;
`else
    neg = 1'b0;
`endif
    exp_q.push_back(model_op(beats, n, neg));
    busy_mask = '0;
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.wbits    = (k == 0) ? wb : (wb ^ CW'(3));
      bus.w_signed = (k == 0) ? ws : ~ws;
      for (int l = 0; l < LANES; l++) bus.pp[l*IN_W +: IN_W] = IN_W'(beats[k][l]);
      #1;
      busy_mask[k] = bus.busy;
      tries = 0;
      while ((bus.in_ready !== 1'b1) && (tries < 50)) begin
        @(negedge clk); #1; tries++;
      end
      if (tries >= 50) begin
        n_cmp++; n_err++;
        $display("FAIL send_op_ready: in_ready=%b required 1 (beat %0d)", bus.in_ready, k);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.acc !== '0) begin n_err++; $display("FAIL reset_acc: got %h want 0", bus.acc); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_unsigned();
    logic signed [AW-1:0] l0;
    vec_t e;
    bus.out_ready = 1'b0;
    beats[0] = '{3, 10, -5, 100};
    beats[1] = '{0, -1, 7, 4095};
    beats[2] = '{1, 2, -4096, 0};
    beats[3] = '{2, 3, 1, -1};
    send_op(4, CW'(4), 1'b0);
    e = exp_q.pop_front();
    l0 = bus.acc[AW-1:0];
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL unsigned_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (l0 !== AW'(28)) begin n_err++; $display("FAIL unsigned_lane0: got %0d want 28", l0); end
    n_cmp++; if (bus.acc !== e) begin n_err++; $display("FAIL unsigned_acc: got %h want %h", bus.acc, e); end
    n_cmp++; if (busy_mask[3:0] !== 4'b1110) begin n_err++; $display("FAIL unsigned_busy: got %b want 1110", busy_mask[3:0]); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL unsigned_busy_end: got %b want 0", bus.busy); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL unsigned_consume: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_signed();
    logic signed [AW-1:0] l0, want;
    vec_t e;
    beats[0] = '{5, -7, 4095, -4096};
    beats[1] = '{0, 2, 0, 1};
    beats[2] = '{0, 0, -3, 2};
    beats[3] = '{1, 5, 9, -8};
    send_op(4, CW'(4), 1'b1);
    e = exp_q.pop_front();
`ifdef SMAC_SIGNED_W_EN
    want = AW'(-39);
`else
    want = AW'(41);
`endif
    l0 = bus.acc[AW-1:0];
    n_cmp++; if (l0 !== want) begin n_err++; $display("FAIL signed_lane0: got %0d want %0d", l0, want); end
    n_cmp++; if (bus.acc !== e) begin n_err++; $display("FAIL signed_acc: got %h want %h", bus.acc, e); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_lanes();
    vec_t e, want_v;
    beats[0] = '{-2, 7, 0, 4095};
    want_v[0*AW +: AW] = AW'(-2);
    want_v[1*AW +: AW] = AW'(7);
    want_v[2*AW +: AW] = AW'(0);
    want_v[3*AW +: AW] = AW'(4095);
    send_op(1, CW'(1), 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL lanes_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.acc !== want_v) begin n_err++; $display("FAIL lanes_acc: got %h want %h", bus.acc, want_v); end
    n_cmp++; if (bus.acc !== e) begin n_err++; $display("FAIL lanes_model: got %h want %h", bus.acc, e); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t r1, r2;
    bus.out_ready = 1'b0;
    beats[0] = '{9, -9, 1, 100};
    beats[1] = '{1, 2, 3, 4};
    send_op(2, CW'(2), 1'b0);
    r1 = exp_q.pop_front();
    beats[0] = '{1, 2, 3, -4};
    beats[1] = '{4, 3, 2, 1};
    beats[2] = '{-1, 0, 1, 2};
    beats[3] = '{7, 7, -7, 0};
    r2 = model_op(beats, 4, 1'b0);
    exp_q.push_back(r2);
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.wbits    = CW'(4);
      bus.w_signed = 1'b0;
      for (int l = 0; l < LANES; l++) bus.pp[l*IN_W +: IN_W] = IN_W'(beats[k][l]);
      #1;
      if (k < 3) begin
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_beat%0d: got %b want 1", k, bus.in_ready); end
        @(negedge clk);
      end
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.acc !== r1 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_hold1: got %h/%b want %h/1", bus.acc, bus.out_valid, r1); end
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall2: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.acc !== r1 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_hold2: got %h/%b want %h/1", bus.acc, bus.out_valid, r1); end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_release: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    r2 = exp_q.pop_front();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid2: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.acc !== r2) begin n_err++; $display("FAIL b2b_acc2: got %h want %h", bus.acc, r2); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_clear();
    vec_t prior, e;
    beats[0] = '{-100, 55, 3, 12};
    send_op(1, CW'(1), 1'b0);
    prior = exp_q.pop_front();
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.wbits    = CW'(4);
      for (int l = 0; l < LANES; l++) bus.pp[l*IN_W +: IN_W] = IN_W'(k + l + 1);
      @(negedge clk);
    end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL clear_busy_before: got %b want 1", bus.busy); end
    cl_en = 1'b1;
    bus.pp = '1;
    @(negedge clk);
    cl_en = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL clear_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.acc !== prior) begin n_err++; $display("FAIL clear_keep: got %h/%b want %h/1", bus.acc, bus.out_valid, prior); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    beats[0] = '{2, -3, 11, 0};
    beats[1] = '{1, 1, -1, 5};
    beats[2] = '{0, 6, 2, -9};
    beats[3] = '{3, -2, 4, 8};
    send_op(4, CW'(4), 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.acc !== e) begin n_err++; $display("FAIL clear_fresh: got %h/%b want %h/1", bus.acc, bus.out_valid, e); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wbits_reset();
    logic signed [AW-1:0] l0;
    vec_t e;
    for (int k = 0; k < 8; k++) beats[k] = '{1, (k % 2 == 0) ? -4096 : 4095, k, -k};
    send_op(8, CW'(0), 1'b0);
    e = exp_q.pop_front();
    l0 = bus.acc[AW-1:0];
    n_cmp++; if (l0 !== AW'(255)) begin n_err++; $display("FAIL wbits0_lane0: got %0d want 255", l0); end
    n_cmp++; if (bus.acc !== e) begin n_err++; $display("FAIL wbits0_acc: got %h want %h", bus.acc, e); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) beats[k] = '{k - 3, 2 * k, 4095 - k, -1};
    send_op(8, CW'(12), 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (bus.acc !== e || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL wbits_big_acc: got %h/%b want %h/1", bus.acc, bus.out_valid, e); end
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.wbits    = CW'(8);
      bus.pp       = '1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.acc !== '0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_mid: got %h/%b/%b want 0/0/0", bus.acc, bus.out_valid, bus.busy); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beats[0] = '{6, -6, 1, 0};
    beats[1] = '{1, 0, 1, 3};
    beats[2] = '{-2, 4, 1, 1};
    send_op(3, CW'(3), 1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (bus.acc !== e || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL after_reset_acc: got %h/%b want %h/1", bus.acc, bus.out_valid, e); end
  endtask

  initial begin
    rst_n         = 1'b0;
    cl_en         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pp        = '0;
    bus.wbits     = '0;
    bus.w_signed  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_lanes();
    test_back_to_back();
    test_clear();
    test_wbits_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
